// File: rtl/mem_stage_nport.sv
// Memory-access pipeline stage: drives LANES data-RAM ports, resolves same-slot
// lane conflicts, forwards same-slot write data to reading lanes, broadcasts
// lane writes to sub-core memories and carries metadata aligned to RAM latency.
module mem_stage_nport #(
    parameter int unsigned LANES       = 2,
    parameter int unsigned ADDR_W      = 17,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned META_W      = 100,
    parameter int unsigned RD_LAT      = 1,
    parameter int unsigned SUBCORE_NUM = 4
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             interlock,
    input  logic [3:0]                       living_sub_count,
    input  logic [SUBCORE_NUM-1:0]           sub_mask,
    input  logic                             in_valid,
    input  logic [META_W-1:0]                in_meta,
    input  logic [LANES*32-1:0]              lane_addr,
    input  logic [LANES*DATA_W-1:0]          lane_din,
    input  logic [LANES-1:0]                 lane_we,
    input  logic [LANES*5-1:0]               lane_rt,
    output logic [LANES-1:0]                 ram_en,
    output logic [LANES*(ADDR_W+2)-1:0]      ram_addr,
    output logic [LANES*DATA_W-1:0]          ram_din,
    output logic [LANES-1:0]                 ram_we,
    input  logic [LANES*DATA_W-1:0]          ram_dout,
    output logic [LANES*(ADDR_W+2)-1:0]      sub_addr,
    output logic [LANES*DATA_W-1:0]          sub_din,
    output logic [SUBCORE_NUM*LANES-1:0]     sub_we,
    output logic                             out_valid,
    output logic [META_W-1:0]                out_meta,
    output logic [LANES*5-1:0]               out_rt,
    output logic [LANES*DATA_W-1:0]          out_dout,
    output logic                             wr_conflict,
    output logic [15:0]                      conflict_count
);

    localparam int unsigned BA_W   = ADDR_W + 2;
    localparam int unsigned LA_W   = 32;
    localparam int unsigned RT_W   = 5;
    localparam int unsigned STAGES = RD_LAT + 1;
    localparam int unsigned LAST   = STAGES - 1;

    // Request-stage combinational results
    logic [ADDR_W-1:0]            w_addr [LANES];
    logic [LANES-1:0]             w_we;
    logic [LANES-1:0]             w_we_res;
    logic [LANES-1:0]             w_fwd;
    logic [LANES*DATA_W-1:0]      w_fwd_data;
    logic                         w_conflict;
    logic                         w_sub_gate;
    logic [SUBCORE_NUM*LANES-1:0] w_sub_we;
    logic                         w_unused_addr;

    // RAM / broadcast registers
    logic [LANES*BA_W-1:0]        r_ram_addr;
    logic [LANES*DATA_W-1:0]      r_ram_din;
    logic [LANES-1:0]             r_ram_we;
    logic [SUBCORE_NUM*LANES-1:0] r_sub_we;
    logic                         r_wr_conflict;
    logic [15:0]                  r_conflict_count;

    // Latency-matching pipeline
    logic                         r_p_valid [STAGES];
    logic [META_W-1:0]            r_p_meta  [STAGES];
    logic [LANES*RT_W-1:0]        r_p_rt    [STAGES];
    logic [LANES-1:0]             r_p_fwd   [STAGES];
    logic [LANES*DATA_W-1:0]      r_p_fdata [STAGES];

    // Result registers
    logic                         r_out_valid;
    logic [META_W-1:0]            r_out_meta;
    logic [LANES*RT_W-1:0]        r_out_rt;
    logic [LANES*DATA_W-1:0]      r_out_dout;

    // Only the low ADDR_W bits of each lane address are meaningful
    assign w_unused_addr = ^lane_addr;
    assign w_sub_gate    = (living_sub_count == 4'd0);

    // Conflict resolution, same-slot forwarding and broadcast gating
    always_comb begin
        w_we       = '0;
        w_we_res   = '0;
        w_fwd      = '0;
        w_fwd_data = '0;
        w_conflict = 1'b0;
        w_sub_we   = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            w_addr[k] = lane_addr[k*LA_W +: ADDR_W];
            w_we[k]   = in_valid & lane_we[k];
        end
        // a writer loses to any higher-index writer of the same address
        for (int unsigned k = 0; k < LANES; k++) begin
            w_we_res[k] = w_we[k];
            for (int unsigned j = k + 1; j < LANES; j++) begin
                if (w_we[k] && w_we[j] && (w_addr[j] == w_addr[k])) begin
                    w_we_res[k] = 1'b0;
                    w_conflict  = 1'b1;
                end
            end
        end
        // ascending scan leaves the highest-index (winning) writer's data
        for (int unsigned j = 0; j < LANES; j++) begin
            if (!w_we[j]) begin
                for (int unsigned k = 0; k < LANES; k++) begin
                    if (w_we[k] && (w_addr[k] == w_addr[j])) begin
                        w_fwd[j]                        = 1'b1;
                        w_fwd_data[j*DATA_W +: DATA_W] = lane_din[k*DATA_W +: DATA_W];
                    end
                end
            end
        end
        for (int unsigned i = 0; i < SUBCORE_NUM; i++) begin
            for (int unsigned k = 0; k < LANES; k++) begin
                w_sub_we[i*LANES + k] = w_we_res[k] & sub_mask[i] & w_sub_gate;
            end
        end
    end

    // Request stage: issue RAM/broadcast ports and track conflicts
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ram_addr       <= '0;
            r_ram_din        <= '0;
            r_ram_we         <= '0;
            r_sub_we         <= '0;
            r_wr_conflict    <= 1'b0;
            r_conflict_count <= '0;
        end else if (!interlock) begin
            for (int unsigned k = 0; k < LANES; k++) begin
                r_ram_addr[k*BA_W +: BA_W] <= {w_addr[k], 2'b00};
            end
            r_ram_din     <= lane_din;
            r_ram_we      <= w_we_res;
            r_sub_we      <= w_sub_we;
            r_wr_conflict <= w_conflict;
            if (w_conflict && (r_conflict_count != 16'hFFFF)) begin
                r_conflict_count <= r_conflict_count + 16'd1;
            end
        end
    end

    // Metadata and forward-data pipeline matched to RAM read latency
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned s = 0; s < STAGES; s++) begin
                r_p_valid[s] <= 1'b0;
                r_p_meta[s]  <= '0;
                r_p_rt[s]    <= '0;
                r_p_fwd[s]   <= '0;
                r_p_fdata[s] <= '0;
            end
        end else if (!interlock) begin
            r_p_valid[0] <= in_valid;
            r_p_meta[0]  <= in_meta;
            r_p_rt[0]    <= lane_rt;
            r_p_fwd[0]   <= w_fwd;
            r_p_fdata[0] <= w_fwd_data;
            for (int unsigned s = 1; s < STAGES; s++) begin
                r_p_valid[s] <= r_p_valid[s-1];
                r_p_meta[s]  <= r_p_meta[s-1];
                r_p_rt[s]    <= r_p_rt[s-1];
                r_p_fwd[s]   <= r_p_fwd[s-1];
                r_p_fdata[s] <= r_p_fdata[s-1];
            end
        end
    end

    // Result stage: capture RAM data or the same-slot forwarded write data
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_out_valid <= 1'b0;
            r_out_meta  <= '0;
            r_out_rt    <= '0;
            r_out_dout  <= '0;
        end else if (!interlock) begin
            r_out_valid <= r_p_valid[LAST];
            r_out_meta  <= r_p_meta[LAST];
            r_out_rt    <= r_p_rt[LAST];
            for (int unsigned k = 0; k < LANES; k++) begin
                r_out_dout[k*DATA_W +: DATA_W] <= r_p_fwd[LAST][k]
                    ? r_p_fdata[LAST][k*DATA_W +: DATA_W]
                    : ram_dout[k*DATA_W +: DATA_W];
            end
        end
    end

    // RAM enable freezes RAM writes and read data during interlock
    assign ram_en         = {LANES{~interlock}};
    assign ram_addr       = r_ram_addr;
    assign ram_din        = r_ram_din;
    assign ram_we         = r_ram_we;
    assign sub_addr       = r_ram_addr;
    assign sub_din        = r_ram_din;
    assign sub_we         = r_sub_we;
    assign wr_conflict    = r_wr_conflict;
    assign conflict_count = r_conflict_count;
    assign out_valid      = r_out_valid;
    assign out_meta       = r_out_meta;
    assign out_rt         = r_out_rt;
    assign out_dout       = r_out_dout;

endmodule

// File: tb/tb_mem_stage_nport.sv
// Bench for mem_stage_nport: behavioural RAM on the ports, reference model of
// slot semantics (winner-per-address, forwarding, in-order delivery).
module tb_mem_stage_nport;

    logic         clk;
    logic         rstn;
    logic         interlock;
    logic [3:0]   living_sub_count;
    logic [3:0]   sub_mask;
    logic         in_valid;
    logic [99:0]  in_meta;
    logic [63:0]  lane_addr;
    logic [63:0]  lane_din;
    logic [1:0]   lane_we;
    logic [9:0]   lane_rt;
    logic [1:0]   ram_en;
    logic [37:0]  ram_addr;
    logic [63:0]  ram_din;
    logic [1:0]   ram_we;
    logic [63:0]  ram_dout = '0;
    logic [37:0]  sub_addr;
    logic [63:0]  sub_din;
    logic [7:0]   sub_we;
    logic         out_valid;
    logic [99:0]  out_meta;
    logic [9:0]   out_rt;
    logic [63:0]  out_dout;
    logic         wr_conflict;
    logic [15:0]  conflict_count;

    mem_stage_nport dut (
        .clk(clk), .rstn(rstn), .interlock(interlock),
        .living_sub_count(living_sub_count), .sub_mask(sub_mask),
        .in_valid(in_valid), .in_meta(in_meta), .lane_addr(lane_addr),
        .lane_din(lane_din), .lane_we(lane_we), .lane_rt(lane_rt),
        .ram_en(ram_en), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_we(ram_we), .ram_dout(ram_dout), .sub_addr(sub_addr),
        .sub_din(sub_din), .sub_we(sub_we), .out_valid(out_valid),
        .out_meta(out_meta), .out_rt(out_rt), .out_dout(out_dout),
        .wr_conflict(wr_conflict), .conflict_count(conflict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Dual-port RAM, latency 1, read-first, frozen when not enabled
    logic [31:0] ram_mem [32] = '{default: 32'd0};
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (ram_en[k]) begin
                ram_dout[k*32 +: 32] <= ram_mem[ram_addr[k*19+2 +: 5]];
                if (ram_we[k]) ram_mem[ram_addr[k*19+2 +: 5]] <= ram_din[k*32 +: 32];
            end
        end
    end

    typedef struct {
        logic        valid;
        logic [99:0] meta;
        logic [9:0]  rt;
        logic [63:0] dout;
        logic [1:0]  chk;
    } exp_t;

    exp_t        q[$];
    exp_t        cur;
    logic [31:0] mem_m [32];
    logic [1:0]  e_ram_we;
    logic [37:0] e_ram_addr;
    logic [63:0] e_ram_din;
    logic [7:0]  e_sub_we;
    logic        e_conf;
    logic [15:0] e_cnt;
    int          n_checks;
    int          n_fail;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic exp_t zero_exp();
        exp_t e;
        e.valid = 1'b0;
        e.meta  = '0;
        e.rt    = '0;
        e.dout  = '0;
        e.chk   = 2'b11;
        return e;
    endfunction

    task automatic model_clear();
        q.delete();
        cur        = zero_exp();
        e_ram_we   = '0;
        e_ram_addr = '0;
        e_ram_din  = '0;
        e_sub_we   = '0;
        e_conf     = 1'b0;
        e_cnt      = '0;
    endtask

    task automatic check_all();
        check("out_valid", 128'(out_valid), 128'(cur.valid));
        check("out_meta", 128'(out_meta), 128'(cur.meta));
        check("out_rt", 128'(out_rt), 128'(cur.rt));
        for (int k = 0; k < 2; k++) begin
            if (cur.chk[k]) check($sformatf("out_dout%0d", k), 128'(out_dout[k*32 +: 32]), 128'(cur.dout[k*32 +: 32]));
        end
        check("ram_we", 128'(ram_we), 128'(e_ram_we));
        check("ram_addr", 128'(ram_addr), 128'(e_ram_addr));
        check("ram_din", 128'(ram_din), 128'(e_ram_din));
        check("sub_we", 128'(sub_we), 128'(e_sub_we));
        check("sub_addr", 128'(sub_addr), 128'(e_ram_addr));
        check("sub_din", 128'(sub_din), 128'(e_ram_din));
        check("wr_conflict", 128'(wr_conflict), 128'(e_conf));
        check("conflict_count", 128'(conflict_count), 128'(e_cnt));
    endtask

    // One cycle: check current outputs, drive a slot, predict the next edge
    task automatic step(input logic v, input logic [1:0] we, input logic [16:0] a0, input logic [16:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1, input logic il,
                        input logic [3:0] lsc, input logic [3:0] sm);
        logic [16:0] a[2];
        logic [31:0] d[2];
        logic [1:0]  wr;
        logic [1:0]  rw;
        int          win[int];
        int          nwr;
        exp_t        e;
        logic [99:0] m;
        logic [9:0]  rt;
        check_all();
        a[0] = a0; a[1] = a1; d[0] = d0; d[1] = d1;
        m  = {$urandom, $urandom, $urandom, 4'($urandom)};
        rt = 10'($urandom);
        in_valid         = v;
        lane_we          = we;
        lane_addr        = {15'($urandom), a1, 15'($urandom), a0};
        lane_din         = {d1, d0};
        in_meta          = m;
        lane_rt          = rt;
        interlock        = il;
        living_sub_count = lsc;
        sub_mask         = sm;
        #1;
        check("ram_en", 128'(ram_en), 128'(il ? 2'b00 : 2'b11));
        if (!il) begin
            // previous slot's surviving writes land in the RAM on this edge
            for (int k = 0; k < 2; k++) begin
                if (e_ram_we[k]) mem_m[e_ram_addr[k*19+2 +: 5]] = e_ram_din[k*32 +: 32];
            end
            wr  = v ? we : 2'b00;
            nwr = 0;
            for (int k = 0; k < 2; k++) begin
                if (wr[k]) begin
                    win[int'(a[k])] = k;
                    nwr++;
                end
            end
            rw = 2'b00;
            for (int k = 0; k < 2; k++) begin
                if (wr[k]) rw[k] = (win[int'(a[k])] == k);
            end
            e_conf = (nwr > win.num());
            if (e_conf && e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
            e_ram_we   = rw;
            e_ram_addr = {a1, 2'b00, a0, 2'b00};
            e_ram_din  = {d1, d0};
            for (int i = 0; i < 4; i++) begin
                for (int k = 0; k < 2; k++) begin
                    e_sub_we[i*2+k] = rw[k] & sm[i] & (lsc == 4'd0);
                end
            end
            e.valid = v;
            e.meta  = m;
            e.rt    = rt;
            e.dout  = '0;
            e.chk   = v ? ~wr : 2'b00;
            for (int k = 0; k < 2; k++) begin
                if (!wr[k]) begin
                    if (win.exists(int'(a[k]))) e.dout[k*32 +: 32] = d[win[int'(a[k])]];
                    else                        e.dout[k*32 +: 32] = mem_m[a[k][4:0]];
                end
            end
            q.push_back(e);
            if (q.size() == 3) cur = q.pop_front();
            else               cur.chk = 2'b00;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 2'b00, 17'd0, 17'd0, 32'd0, 32'd0, 1'b0, 4'd0, 4'd0);
    endtask

    task automatic rand_step(input logic il);
        step(($urandom % 5) != 0, 2'($urandom), 17'($urandom_range(0, 7)), 17'($urandom_range(0, 7)),
             $urandom, $urandom, il,
             (($urandom % 4) == 0) ? 4'($urandom_range(1, 15)) : 4'd0, 4'($urandom));
    endtask

    // Asynchronous reset between edges with slots in flight
    task automatic mid_reset();
        check_all();
        #3;
        rstn      = 1'b0;
        in_valid  = 1'b0;
        lane_we   = 2'b00;
        interlock = 1'b0;
        model_clear();
        #1;
        check_all();
        check("ram_en_rst", 128'(ram_en), 128'(2'b11));
        @(negedge clk);
        check_all();
        #1;
        rstn = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 32; i++) mem_m[i] = 32'd0;
        rstn = 1'b0; interlock = 1'b0; living_sub_count = 4'd0; sub_mask = 4'd0;
        in_valid = 1'b0; in_meta = '0; lane_addr = '0; lane_din = '0; lane_we = '0; lane_rt = '0;
        model_clear();
        repeat (2) @(negedge clk);
        check_all();
        check("ram_en_reset", 128'(ram_en), 128'(2'b11));
        #1 rstn = 1'b1;

        // write then dependent read of the same address in the next slot
        step(1'b1, 2'b01, 17'd5, 17'd9, 32'hDEADBEEF, 32'd0, 1'b0, 4'd0, 4'd0);
        check("tp1_ram_addr", 128'(ram_addr[18:0]), 128'(19'h14));
        step(1'b1, 2'b00, 17'd9, 17'd5, 32'd0, 32'd0, 1'b0, 4'd0, 4'd0);
        idle();
        idle();
        check("tp1_dout1", 128'(out_dout[63:32]), 128'(32'hDEADBEEF));

        // write-write conflict on one address
        step(1'b1, 2'b11, 17'd7, 17'd7, 32'h1111, 32'h2222, 1'b0, 4'd0, 4'd0);
        check("tp2_ram_we", 128'(ram_we), 128'(2'b10));
        check("tp2_conflict", 128'(wr_conflict), 128'(1'b1));
        check("tp2_count", 128'(conflict_count), 128'(16'd1));
        idle();
        check("tp2_conflict_clr", 128'(wr_conflict), 128'(1'b0));
        step(1'b1, 2'b00, 17'd7, 17'd1, 32'd0, 32'd0, 1'b0, 4'd0, 4'd0);
        idle();
        idle();
        check("tp2_read7", 128'(out_dout[31:0]), 128'(32'h2222));

        // same-slot read/write forwarding
        step(1'b1, 2'b10, 17'd3, 17'd3, 32'd0, 32'hABCD, 1'b0, 4'd0, 4'd0);
        idle();
        idle();
        check("tp3_fwd", 128'(out_dout[31:0]), 128'(32'hABCD));

        // broadcast gating
        step(1'b1, 2'b10, 17'd1, 17'd2, 32'd0, 32'h55, 1'b0, 4'd0, 4'b0101);
        check("tp4_sub_we", 128'(sub_we), 128'(8'b00100010));
        step(1'b1, 2'b10, 17'd1, 17'd2, 32'd0, 32'h66, 1'b0, 4'd2, 4'b0101);
        check("tp4_sub_we_gated", 128'(sub_we), 128'(8'd0));

        // three slots in flight, interlock for three cycles
        step(1'b1, 2'b01, 17'd4, 17'd6, 32'hA0A0, 32'd0, 1'b0, 4'd0, 4'd0);
        step(1'b1, 2'b00, 17'd6, 17'd4, 32'd0, 32'd0, 1'b0, 4'd0, 4'd0);
        step(1'b1, 2'b10, 17'd2, 17'd4, 32'd0, 32'hB1B1, 1'b0, 4'd0, 4'd0);
        repeat (3) rand_step(1'b1);
        repeat (4) idle();

        // reset with slots in flight
        step(1'b1, 2'b00, 17'd4, 17'd2, 32'd0, 32'd0, 1'b0, 4'd0, 4'd0);
        step(1'b1, 2'b11, 17'd5, 17'd5, 32'h77, 32'h88, 1'b0, 4'd0, 4'd3);
        mid_reset();
        repeat (3) idle();

        // randomized traffic with interlock bubbles
        for (int n = 0; n < 400; n++) rand_step(($urandom % 5) == 0);
        repeat (3) idle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
